// File: rtl/clock_ctrl_sched.sv
// Digital clock control scheduler: held-button auto-repeat pulses, time/alarm pulse routing and alarm ring FSM.
// Define SNOOZE_EN to add a snooze state entered when a button dismisses the ringing alarm.
module clock_ctrl_sched #(
  parameter int REPEAT_DELAY   = 50_000_000,
  parameter int REPEAT_PERIOD  = 25_000_000,
  parameter int BEEP_HALF      = 25_000_000,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       tick_hr,
  input  logic       tick_min,
  input  logic       set_alarm,
  input  logic       alarm_en,
  input  logic [4:0] time_hr,
  input  logic [5:0] time_min,
  input  logic [5:0] time_sec,
  input  logic [4:0] alarm_hr,
  input  logic [5:0] alarm_min,
  output logic       inc_time_hr,
  output logic       inc_time_min,
  output logic       inc_alarm_hr,
  output logic       inc_alarm_min,
  output logic       ringing,
  output logic       buzzer
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BW      = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
  localparam int SEC_MAX = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
  localparam int SW      = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;

  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [BW-1:0] BEEP_LAST   = BW'(BEEP_HALF - 1);
  localparam logic [SW-1:0] RING_LAST   = SW'(RING_TIMEOUT_S - 1);
`ifdef SNOOZE_EN
  localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_S - 1);
`endif

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_DELAY,
    CH_REPEAT
  } ch_state_t;

  typedef enum logic [1:0] {
    RG_IDLE,
    RG_RING,
    RG_DONE
`ifdef SNOOZE_EN
    , RG_SNOOZE
`endif
  } ring_state_t;

  ring_state_t     ring_state_reg;
  logic [SW-1:0]   secs_reg;
  logic [BW-1:0]   beep_cnt_reg;
  logic            buzzer_reg;
  logic            ringing_reg;

  // Channel 0 is the hour button, channel 1 the minute button.
  logic [1:0] btn;
  logic [1:0] rise;
  logic [1:0] time_pulse;
  logic [1:0] alarm_pulse;
  logic       in_ring;
  logic       match;
  logic       dismiss;

  assign btn     = {tick_min, tick_hr};
  assign in_ring = (ring_state_reg == RG_RING);
  assign dismiss = |rise;
  assign match   = alarm_en & ~set_alarm & (time_hr == alarm_hr) &
                   (time_min == alarm_min) & (time_sec == 6'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      ch_state_t     state_reg;
      logic [CW-1:0] cnt_reg;
      logic          prev_reg;
      logic          time_reg;
      logic          alarm_reg;

      assign rise[gi]        = btn[gi] & ~prev_reg;
      assign time_pulse[gi]  = time_reg;
      assign alarm_pulse[gi] = alarm_reg;

      always_ff @(posedge clk_100MHz) begin
        if (reset) begin
          state_reg <= CH_IDLE;
          cnt_reg   <= '0;
          prev_reg  <= 1'b0;
          time_reg  <= 1'b0;
          alarm_reg <= 1'b0;
        end else begin
          prev_reg  <= btn[gi];
          time_reg  <= 1'b0;
          alarm_reg <= 1'b0;
          if (!btn[gi]) begin
            state_reg <= CH_IDLE;
            cnt_reg   <= '0;
          end else begin
            case (state_reg)
              CH_IDLE: begin
                // A press that silences the alarm is swallowed here.
                if (rise[gi] && !in_ring) begin
                  state_reg <= CH_DELAY;
                  cnt_reg   <= '0;
                  time_reg  <= ~set_alarm;
                  alarm_reg <= set_alarm;
                end
              end
              CH_DELAY: begin
                if (cnt_reg >= DELAY_LAST) begin
                  state_reg <= CH_REPEAT;
                  cnt_reg   <= '0;
                  time_reg  <= ~set_alarm;
                  alarm_reg <= set_alarm;
                end else begin
                  cnt_reg <= cnt_reg + 1'b1;
                end
              end
              CH_REPEAT: begin
                if (cnt_reg >= PERIOD_LAST) begin
                  cnt_reg   <= '0;
                  time_reg  <= ~set_alarm;
                  alarm_reg <= set_alarm;
                end else begin
                  cnt_reg <= cnt_reg + 1'b1;
                end
              end
              default: begin
                state_reg <= CH_IDLE;
                cnt_reg   <= '0;
              end
            endcase
          end
        end
      end
    end
  endgenerate

  assign inc_time_hr   = time_pulse[0];
  assign inc_time_min  = time_pulse[1];
  assign inc_alarm_hr  = alarm_pulse[0];
  assign inc_alarm_min = alarm_pulse[1];

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      ring_state_reg <= RG_IDLE;
      secs_reg       <= '0;
      beep_cnt_reg   <= '0;
      buzzer_reg     <= 1'b0;
      ringing_reg    <= 1'b0;
    end else begin
      case (ring_state_reg)
        RG_IDLE: begin
          if (match) begin
            ring_state_reg <= RG_RING;
            secs_reg       <= '0;
            beep_cnt_reg   <= '0;
            buzzer_reg     <= 1'b1;
            ringing_reg    <= 1'b1;
          end
        end
        RG_RING: begin
          if (!alarm_en || (tick_1hz && secs_reg >= RING_LAST)) begin
            ring_state_reg <= RG_DONE;
            buzzer_reg     <= 1'b0;
            ringing_reg    <= 1'b0;
          end else if (dismiss) begin
`ifdef SNOOZE_EN
            ring_state_reg <= RG_SNOOZE;
            secs_reg       <= '0;
`else
            ring_state_reg <= RG_DONE;
`endif
            buzzer_reg     <= 1'b0;
            ringing_reg    <= 1'b0;
          end else begin
            if (tick_1hz) begin
              secs_reg <= secs_reg + 1'b1;
            end
            if (beep_cnt_reg >= BEEP_LAST) begin
              beep_cnt_reg <= '0;
              buzzer_reg   <= ~buzzer_reg;
            end else begin
              beep_cnt_reg <= beep_cnt_reg + 1'b1;
            end
          end
        end
        RG_DONE: begin
          // Holding here until the minute moves on stops a retrigger in the same minute.
          if ((time_min != alarm_min) || !alarm_en) begin
            ring_state_reg <= RG_IDLE;
          end
        end
`ifdef SNOOZE_EN
        RG_SNOOZE: begin
          if (!alarm_en) begin
            ring_state_reg <= RG_IDLE;
          end else if (tick_1hz) begin
            if (secs_reg >= SNOOZE_LAST) begin
              ring_state_reg <= RG_RING;
              secs_reg       <= '0;
              beep_cnt_reg   <= '0;
              buzzer_reg     <= 1'b1;
              ringing_reg    <= 1'b1;
            end else begin
              secs_reg <= secs_reg + 1'b1;
            end
          end
        end
`endif
        default: begin
          ring_state_reg <= RG_IDLE;
          buzzer_reg     <= 1'b0;
          ringing_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign ringing = ringing_reg;
  assign buzzer  = buzzer_reg;

endmodule

// File: doc/clock_ctrl_sched.md
Name: clock_ctrl_sched

Overview:
- Control scheduler between the user inputs and the timekeeping/alarm datapath of the digital clock.
- Converts held hour/minute buttons into single-cycle increment pulses, with an initial pulse followed by auto-repeat.
- Routes those pulses to either the time counters or the alarm registers.
- Runs the alarm ring state machine that drives buzzer.

Parameters:
- REPEAT_DELAY, 50_000_000: cycles a button must be held after the first pulse before auto-repeat starts.
- REPEAT_PERIOD, 25_000_000: cycles between auto-repeat pulses.
- BEEP_HALF, 25_000_000: cycles per buzzer half-period while ringing.
- RING_TIMEOUT_S, 60: tick_1hz pulses after which ringing stops on its own.
- SNOOZE_S, 300: snooze length in tick_1hz pulses. Used only with SNOOZE_EN.

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  synchronous, active-high
- tick_1hz  in  1  one-cycle pulse once per second
- tick_hr  in  1  debounced hour button level
- tick_min  in  1  debounced minute button level
- set_alarm  in  1  level; 1 = adjust alarm, 0 = adjust time
- alarm_en  in  1  level; alarm armed
- time_hr  in  5  current hour, 0-23
- time_min  in  6  current minute, 0-59
- time_sec  in  6  current second, 0-59
- alarm_hr  in  5  alarm hour
- alarm_min  in  6  alarm minute
- inc_time_hr  out  1  one-cycle pulse
- inc_time_min  out  1  one-cycle pulse
- inc_alarm_hr  out  1  one-cycle pulse
- inc_alarm_min  out  1  one-cycle pulse
- ringing  out  1  high while the ring FSM is in RING
- buzzer  out  1  audible square wave

Behaviour:
- Clock and reset: single clock, clk_100MHz. reset is synchronous and active-high.
- Reset state: all outputs 0, all counters 0, all FSMs IDLE, button history registers 0.
- Reset asserted mid-ring or mid-hold: outputs are 0 on the cycle after the reset edge.
- Button channels: two identical, independent channels (hr, min). Each channel registers its input as prev. Rise = level & ~prev.
- Channel FSM states: IDLE, DELAY, REPEAT.
  - IDLE --rise--> DELAY. A pulse is emitted on the cycle rise is detected, i.e. registered output 1 cycle after the input edge; the counter is cleared.
  - DELAY: counter increments each cycle. When the count reaches REPEAT_DELAY-1: emit a pulse, clear the counter, go to REPEAT.
  - REPEAT: when the count reaches REPEAT_PERIOD-1: emit a pulse, clear the counter.
  - Level low in any state: go to IDLE next cycle, clear the counter, no pulse.
- Routing: each pulse goes to inc_alarm_* if set_alarm=1 in that pulse's cycle, otherwise to inc_time_*. Toggling set_alarm mid-hold reroutes subsequent pulses.
- Simultaneous buttons: both channels may pulse in the same cycle; both outputs assert. There is no arbitration between the channels.
- Ring FSM states: IDLE, RING, DONE.
  - match = alarm_en & ~set_alarm & (time_hr==alarm_hr) & (time_min==alarm_min) & (time_sec==0).
  - IDLE --match--> RING. The secs counter and beep counter are cleared; buzzer goes 1 on the entry cycle.
  - RING: ringing=1. buzzer inverts every BEEP_HALF cycles. secs increments on tick_1hz.
  - Exit RING to DONE on the first of: alarm_en=0; a rise on either button; secs reaching RING_TIMEOUT_S.
  - A dismissing rise is consumed: no inc_* pulse, and that channel stays IDLE until the button is released and pressed again.
  - Buzzer and ringing deassert on the cycle after the exit condition.
  - DONE --(time_min!=alarm_min or alarm_en=0)--> IDLE. This prevents a retrigger within the same minute.
- Outside RING, buzzer=0 and ringing=0.
- Counters: widths are sized with $clog2 of their parameter, no wrap before the terminal count, saturating compare.

Optional Feature:
- Macro: SNOOZE_EN.
- With the macro defined:
  - An extra state SNOOZE is added.
  - A button-rise dismissal in RING goes to SNOOZE; timeout and alarm_en=0 still go to DONE.
  - SNOOZE counts tick_1hz. At SNOOZE_S it returns to RING with counters cleared.
  - alarm_en=0 in SNOOZE goes to IDLE.
  - In SNOOZE, buzzer=0 and ringing=0.
- Without the macro: SNOOZE does not exist and every dismissal goes to DONE.

Test Plan:
- Bench parameters: REPEAT_DELAY=8, REPEAT_PERIOD=4, BEEP_HALF=2, RING_TIMEOUT_S=3, SNOOZE_S=2.
- Reset: reset=1 for 2 cycles with tick_min=1 held -> all outputs 0; the first inc_time_min occurs 1 cycle after reset falls.
- Auto-repeat: set_alarm=0, tick_hr held 30 cycles -> inc_time_hr pulses at cycles 1, 9, 13, 17, 21, 25, 29 after the press; release -> no further pulses.
- Routing and simultaneity:
  - set_alarm=1 and both buttons pressed in the same cycle -> inc_alarm_hr and inc_alarm_min pulse together; inc_time_* stay 0.
  - set_alarm dropped mid-hold -> the next pulse appears on inc_time_*.
- Ring and timeout: alarm 07:30, alarm_en=1, time stepped to 07:30:00 -> ringing=1 next cycle; buzzer pattern 1,1,0,0,1,1...; 3 tick_1hz pulses -> ringing=0; time held at 07:30:05 -> no retrigger.
- Dismiss: while ringing, pulse tick_min -> ringing=0 next cycle; no inc_time_min pulse.
- SNOOZE_EN build: while ringing, pulse tick_min -> ringing=0; ringing returns after 2 tick_1hz; then alarm_en=0 -> state IDLE, ringing=0.
